fe_unit_arbiter: RTL
====================

Name: fe_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one serial field-subtract unit (mod 2^255-19, one pulse-start/pulse-done, 15-cycle latency) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues each to the unit, waits for completion, and returns the tagged result over a single valid/ready response port.
- Sits between the point-arithmetic sequencers and the shared subtract unit.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: width of resp_id, at least clog2(NREQ).
- DRAIN, 16: cycles after reset before the first issue; must be at least unit latency + 1.
- TMO, 64: cycles in WAIT without unit_done before an error is flagged.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*255  minuend; slot k is bits [k*255 +: 255].
- req_b  in  NREQ*255  subtrahend, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of the result.
- resp_data  out  255  (a-b) mod p, as produced by the unit.
- unit_start  out  1  one-cycle start pulse to the unit.
- unit_a  out  255  operand a to the unit.
- unit_b  out  255  operand b to the unit.
- unit_done  in  1  one-cycle completion pulse from the unit.
- unit_out  in  255  unit result, valid while unit_done=1.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=DRAIN; drain counter=DRAIN.
  - rr pointer=NREQ-1, so requester 0 has first priority.
  - req_ready=0, unit_start=0, resp_valid=0, resp_id=0, resp_data=0, unit_a=0, unit_b=0, err=0.
- Reset mid-operation discards the in-flight request and any pending response. No response is ever produced for it.
- States:
  - DRAIN: counter decrements each cycle; go to IDLE when it reaches 0. Any unit_done seen here is ignored, which absorbs a stray completion from an operation started before reset.
  - IDLE: winner = first k with req_valid[k]=1, searching rr+1, rr+2, ... modulo NREQ.
    - req_ready[winner]=1 combinationally that cycle; all other req_ready bits are 0.
    - On that edge: latch req_a/req_b slot into unit_a/unit_b, latch winner into the tag, set rr=winner, go to ISSUE.
    - No valid: stay in IDLE, rr unchanged.
  - ISSUE: unit_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: unit_a/unit_b held stable.
    - On unit_done: resp_data<=unit_out, resp_id<=tag, go to RESP.
    - Otherwise the timeout counter increments. When it reaches TMO: err<=1, resp_data<=0, resp_id<=tag, go to RESP. The consumer is never left hung.
  - RESP: resp_valid=1, with resp_data/resp_id stable, until resp_ready=1. On the handshake edge go to IDLE.
- unit_done in IDLE, ISSUE or RESP is ignored and never overwrites resp_data.
- Latency with the 15-cycle unit, accept at cycle t:
  - unit_start at t+1.
  - unit_done at t+16.
  - resp_valid at t+17 at the earliest.
- Throughput: at most one outstanding operation. The next accept occurs no earlier than the cycle after the response handshake.
- req_valid deasserting while not granted is legal. A requester must hold its operands stable while req_valid=1 and it has not been accepted.
- err stays set until reset.
- Arithmetic: the block performs none. Data passes through unchanged.

Test Plan:
- Single request, no contention: req0 with a=5, b=3, valid at cycle 0 after drain.
  - req_ready[0] at 0, unit_start at 1.
  - With a bench model of the unit, done at 16; resp_valid at 17 with resp_id=0, resp_data=2.
- Wrap case: a=3, b=5 → resp_data = 2^255-21.
- Round robin: req0..3 all valid continuously, resp_ready=1.
  - Grants in order 0,1,2,3,0.
  - Each resp_id matches its request, with operands a=k+10, b=k giving resp_data=10.
- Back-pressure: hold resp_ready=0 for 20 cycles after resp_valid.
  - resp_valid and resp_data stay stable; no req_ready asserts.
  - unit_start stays low until 1 cycle after the handshake + grant.
- Reset mid-WAIT (cycle 8 after start), with the unit model still pulsing done at 16:
  - No resp_valid is produced.
  - The stray done is ignored during DRAIN.
  - The first post-reset grant goes to requester 0.
- Timeout: the unit model never pulses done.
  - err=1 and resp_valid=1 with resp_data=0 at TMO+2 cycles after unit_start.
  - After the handshake the arbiter resumes granting.

Source files
------------

// File: rtl/fe_unit_arbiter.sv
// fe_unit_arbiter: round-robin sharing of one serial mod-p subtract unit among NREQ requesters
module fe_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DRAIN = 16,
    parameter int TMO   = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*255-1:0] req_a,
    input  logic [NREQ*255-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [254:0]        resp_data,
    output logic                unit_start,
    output logic [254:0]        unit_a,
    output logic [254:0]        unit_b,
    input  logic                unit_done,
    input  logic [254:0]        unit_out,
    output logic                err
);
    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    localparam int DW = $clog2(DRAIN + 1);
    localparam int TW = $clog2(TMO + 1);
    state_t         state;
    logic [DW-1:0]  drain_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic [IDW-1:0] rr, win, idx;
    logic           found;
    // scan from lowest priority up so the last hit is the first requester after rr
    always_comb begin
        win   = rr;
        idx   = rr;
        found = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDW'((int'(rr) + i) % NREQ);
            if (req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    assign req_ready  = (state == S_IDLE && found) ? NREQ'(1) << win : '0;
    assign unit_start = (state == S_ISSUE);
    assign resp_valid = (state == S_RESP);
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN);
            tmo_cnt   <= '0;
            rr        <= IDW'(NREQ - 1);
            resp_id   <= '0;
            resp_data <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_DRAIN: begin
                    if (drain_cnt == '0) state <= S_IDLE;
                    else drain_cnt <= drain_cnt - 1'b1;
                end
                S_IDLE: begin
                    if (found) begin
                        unit_a <= req_a[win*255 +: 255];
                        unit_b <= req_b[win*255 +: 255];
                        rr     <= win;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (unit_done) begin
                        resp_data <= unit_out;
                        resp_id   <= rr;
                        state     <= S_RESP;
                    end else if (tmo_cnt == TW'(TMO)) begin
                        err       <= 1'b1;
                        resp_data <= '0;
                        resp_id   <= rr;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_DRAIN;
            endcase
        end
    end
endmodule
